// File: rtl/dmux_ctrl_pkg.sv
// dmux_ctrl_pkg: shared states, lane constants and helpers for the dispatch controller.
package dmux_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, DROP} state_e;
  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam logic MODE_DIRECTED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] p);
    return p + 1'b1;
  endfunction
endpackage

// File: rtl/dmux_stall_timer.sv
// dmux_stall_timer: counts consecutive stalled cycles and flags expiry on the TIMEOUT-th one.
module dmux_stall_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  assign o_expire = (TIMEOUT != 0) && i_en && (int'(r_cnt) == TIMEOUT - 1);
  // expiry resets the count, so it tops out at TIMEOUT-1 and never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_clear || o_expire) r_cnt <= '0;
    else if (i_en && TIMEOUT != 0) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/dmux_dispatch_ctrl.sv
// dmux_dispatch_ctrl: valid/ready 1-to-4 dispatcher with directed or round-robin lane choice
// and timeout-based dropping of items whose sink stalls.
module dmux_dispatch_ctrl
  import dmux_ctrl_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_mode,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [WIDTH-1:0]       i_in_data,
  input  logic [SEL_W-1:0]       i_in_sel,
  output logic [N_OUT-1:0]       o_out_valid,
  input  logic [N_OUT-1:0]       i_out_ready,
  output logic [N_OUT*WIDTH-1:0] o_out_data,
  output logic [SEL_W-1:0]       o_cur_sel,
  output logic                   o_drop_pulse,
  output logic [CNT_W-1:0]       o_drop_count
);
  state_e           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_hold;
  logic             w_xfer;
  logic             w_accept;
  logic             w_expire;
  assign w_hold   = (r_state == HOLD);
  assign w_xfer   = w_hold && i_out_ready[r_sel];
  // the only input-to-output path: a ready target lets the next item in the same cycle
  assign o_in_ready = rst_n && ((r_state == IDLE) || w_xfer);
  assign w_accept = i_in_valid && o_in_ready;
  dmux_stall_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (!w_hold || w_xfer),
    .i_en    (w_hold && !w_xfer),
    .o_expire(w_expire)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_rr_ptr   <= '0;
      r_data     <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_data <= i_in_data;
        r_sel  <= (i_mode == MODE_RR) ? r_rr_ptr : i_in_sel;
        if (i_mode == MODE_RR) r_rr_ptr <= next_lane(r_rr_ptr);
      end
      case (r_state)
        IDLE: r_state <= i_in_valid ? HOLD : IDLE;
        HOLD: r_state <= w_xfer ? (i_in_valid ? HOLD : IDLE) : (w_expire ? DROP : HOLD);
        DROP: begin
          r_state    <= IDLE;
          r_drop_cnt <= (&r_drop_cnt) ? r_drop_cnt : r_drop_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_comb begin
    o_out_valid = '0;
    o_out_data  = '0;
    if (w_hold) begin
      o_out_valid[r_sel]                      = 1'b1;
      o_out_data[int'(r_sel)*WIDTH +: WIDTH]  = r_data;
    end
  end
  assign o_cur_sel    = w_hold ? r_sel : '0;
  assign o_drop_pulse = (r_state == DROP);
  assign o_drop_count = r_drop_cnt;
endmodule

// File: tb/tb_dmux_dispatch_ctrl.sv
// tb_dmux_dispatch_ctrl: directed stimulus checked every cycle against an item-level model
// of the dispatcher, plus literal expectations at key points.
module tb_dmux_dispatch_ctrl;
  localparam int TO = 4;
  logic       clk = 0, rst_n = 0, mode = 0, in_valid = 0, in_data = 0;
  logic [1:0] in_sel = 0;
  logic [3:0] out_ready = 4'hF;
  logic       in_ready, drop_pulse;
  logic [3:0] out_valid, out_data;
  logic [1:0] cur_sel;
  logic [7:0] drop_count;
  int vectors = 0, miscompares = 0;
  bit m_held = 0, m_drop = 0, m_data = 0;
  int m_lane = 0, m_stall = 0, m_rr = 0, m_drops = 0;

  always #5 clk = ~clk;

  dmux_dispatch_ctrl #(.WIDTH(1), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_mode(mode), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_sel(in_sel), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_cur_sel(cur_sel), .o_drop_pulse(drop_pulse), .o_drop_count(drop_count)
  );

  task automatic chk(input string n, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // item-level model: one held item, a stall counter, and a one-cycle drop marker
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_held = 0; m_drop = 0; m_data = 0; m_lane = 0; m_stall = 0; m_rr = 0; m_drops = 0;
    end else if (m_drop) begin
      m_drop = 0;
      m_drops = (m_drops < 255) ? m_drops + 1 : 255;
    end else begin
      bit xfer, acc;
      xfer = m_held && out_ready[m_lane];
      acc = in_valid && (!m_held || xfer);
      if (m_held && !xfer) begin
        m_stall++;
        if (m_stall == TO) begin m_held = 0; m_drop = 1; m_stall = 0; end
      end else begin
        m_stall = 0;
        m_held = 0;
      end
      if (acc) begin
        m_held = 1;
        m_data = in_data;
        m_lane = mode ? m_rr : int'(in_sel);
        if (mode) m_rr = (m_rr + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    #3;
    chk("in_ready", in_ready, int'(rst_n && !m_drop && (!m_held || out_ready[m_lane])));
    chk("out_valid", out_valid, m_held ? (1 << m_lane) : 0);
    chk("out_data", out_data, (m_held && m_data) ? (1 << m_lane) : 0);
    chk("cur_sel", cur_sel, m_held ? m_lane : 0);
    chk("drop_pulse", drop_pulse, int'(m_drop));
    chk("drop_count", drop_count, m_drops);
  end

  task automatic drive(input bit v, input bit d, input int s, input bit m, input logic [3:0] r);
    @(negedge clk);
    in_valid = v; in_data = d; in_sel = 2'(s); mode = m; out_ready = r;
  endtask

  task automatic lit(input logic [3:0] v, input logic [3:0] d);
    #4;
    chk("lit_valid", out_valid, v);
    chk("lit_data", out_data, d);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #4;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_count", drop_count, 0);
    @(negedge clk); rst_n = 1;
    // directed
    drive(1, 1, 0, 0, 4'hF); #4; chk("dir_ready", in_ready, 1);
    drive(1, 1, 2, 0, 4'hF); lit(4'b0001, 4'b0001);
    drive(1, 0, 3, 0, 4'hF); lit(4'b0100, 4'b0100);
    drive(1, 1, 1, 0, 4'hF); lit(4'b1000, 4'b0000);
    drive(0, 0, 0, 0, 4'hF); lit(4'b0010, 4'b0010);
    drive(0, 0, 0, 0, 4'hF); lit(4'b0000, 4'b0000);
    // round-robin wrap
    for (int i = 0; i < 7; i++) begin
      drive(i < 6, 1, 3, 1, 4'hF);
      if (i > 0) lit(4'(1 << ((i - 1) % 4)), 4'(1 << ((i - 1) % 4)));
    end
    drive(1, 1, 0, 1, 4'hF);
    drive(0, 0, 0, 0, 4'hF); lit(4'b0100, 4'b0100);
    // back-pressure on lane 2
    drive(1, 1, 2, 0, 4'hF);
    repeat (3) begin
      drive(0, 0, 0, 0, 4'b1011); lit(4'b0100, 4'b0100);
      chk("bp_ready", in_ready, 0);
    end
    drive(0, 0, 0, 0, 4'hF); lit(4'b0100, 4'b0100);
    chk("bp_xfer_ready", in_ready, 1);
    drive(0, 0, 0, 0, 4'hF); lit(4'b0000, 4'b0000);
    chk("bp_no_drop", drop_count, 0);
    // single timeout on lane 1
    drive(1, 1, 1, 0, 4'b1101);
    repeat (4) begin
      drive(0, 0, 0, 0, 4'b1101); lit(4'b0010, 4'b0010);
      chk("to_pulse_low", drop_pulse, 0);
    end
    drive(0, 0, 0, 0, 4'b1101); lit(4'b0000, 4'b0000);
    chk("to_pulse", drop_pulse, 1);
    chk("to_drop_ready", in_ready, 0);
    drive(0, 0, 0, 0, 4'b1101); #4;
    chk("to_idle_ready", in_ready, 1);
    chk("to_count", drop_count, 1);
    chk("to_pulse_once", drop_pulse, 0);
    // simultaneous transfer and load after a partial stall
    drive(1, 1, 0, 0, 4'hF);
    drive(0, 0, 0, 0, 4'b1110);
    drive(0, 0, 0, 0, 4'b1110);
    drive(1, 1, 1, 0, 4'hF); lit(4'b0001, 4'b0001);
    chk("sim_ready", in_ready, 1);
    repeat (4) begin
      drive(0, 0, 0, 0, 4'b1101); lit(4'b0010, 4'b0010);
      chk("sim_no_early_drop", drop_pulse, 0);
    end
    drive(0, 0, 0, 0, 4'b1101); #4; chk("sim_drop", drop_pulse, 1);
    // saturation
    repeat (258 * 6) drive(1, 1, 1, 0, 4'b1101);
    drive(0, 0, 0, 0, 4'hF);
    repeat (8) drive(0, 0, 0, 0, 4'hF);
    #4; chk("sat_count", drop_count, 255);
    // asynchronous reset while holding
    drive(1, 1, 3, 1, 4'hF);
    drive(0, 0, 0, 0, 4'h0); #2;
    rst_n = 0; #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 0);
    @(negedge clk); rst_n = 1;
    drive(1, 1, 2, 1, 4'hF);
    drive(0, 0, 0, 0, 4'hF); lit(4'b0001, 4'b0001);
    chk("arst_count", drop_count, 0);
    chk("arst_pulse", drop_pulse, 0);
    repeat (3) drive(0, 0, 0, 0, 4'hF);
    @(negedge clk); #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
